edge_detect_bank: RTL and testbench
===================================

# edge_detect_bank

Multi-channel, parametrised edge detector, the next generation of the single-bit `edge_detect` block. Each channel synchronises an asynchronous input, removes glitches with a debounce filter, and detects rising and/or falling edges as selected per channel. Detected edges produce one-cycle pulses and sticky, software-clearable flags, and the flags are ORed into a single interrupt. The block sits between raw external inputs (buttons, status lines) and control logic or an interrupt controller.

## Interface
- `WIDTH`, default 8: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `FILT_LEN`, default 4: consecutive disagreeing cycles required before the filtered level changes (≥1).

- `clock`  in  1: rising-edge clock, single clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `din`  in  WIDTH: raw inputs, asynchronous to `clock`.
- `mode_rise`  in  WIDTH: per-channel enable for rising-edge detection.
- `mode_fall`  in  WIDTH: per-channel enable for falling-edge detection.
- `clr`  in  WIDTH: per-channel sticky-flag clear, synchronous, level-sensitive.
- `level`  out  WIDTH: debounced, synchronised input level.
- `pulse`  out  WIDTH: one-cycle high on each enabled detected edge.
- `sticky`  out  WIDTH: latched edge flags.
- `irq`  out  1: OR of all `sticky` bits.

## Operation
- Channels are fully independent. Per channel, the data path is synchroniser → filter → edge detect → sticky.
- Synchroniser: a `SYNC_STAGES`-deep shift register. All flops reset to 0. Its last stage is `s`.
- Filter: a counter of width clog2(`FILT_LEN`+1) that resets to 0.
  - If `s` ≠ `level`: the counter increments.
  - When the increment would reach `FILT_LEN`: `level` toggles and the counter clears.
  - If `s` = `level`: the counter clears.
  - A disturbance shorter than `FILT_LEN` cycles never changes `level`.
- Edge: a `level` 0→1 toggle is a rise and a 1→0 toggle is a fall.
  - `pulse` = (rise & `mode_rise`) | (fall & `mode_fall`), registered.
  - `pulse` is high for exactly the one cycle following the toggle edge.
- Mode inputs are sampled at the toggle edge only. Changing a mode never creates or cancels an edge retroactively.
- Sticky: next = (`sticky` & ~`clr`) | pulse-event. Set wins when set and `clr` occur in the same cycle.
- `irq` = |`sticky`, combinational from registers (no extra latency).
- `level` resets to 0. An input held high through reset therefore produces one rising event after the nominal latency once `rst_n` releases.

## Timing
- Reset values: `level`, `pulse`, `sticky`, `irq`, synchronisers and counters are all 0, asserted asynchronously on `rst_n` low.
- Reset deassertion is used as-is; it is synchronised externally.
- Latency: if `din` is stable and first sampled at edge n, then `level`, `pulse` and `sticky` update at edge n+`SYNC_STAGES`+`FILT_LEN`−1. With defaults this is edge n+5.
- `pulse` width is exactly 1 cycle, with no back-to-back pulses from a single toggle.
- Minimum spacing between two edges on one channel is `FILT_LEN` cycles.
- `clr` takes effect at the next rising edge. `irq` falls in the same cycle the last sticky bit clears.
- Simultaneous events on different channels produce simultaneous, independent pulses.
- Reset mid-filter discards partial counts. No pulse is generated by reset itself.

## Test plan
Defaults: `WIDTH`=8, `SYNC_STAGES`=2, `FILT_LEN`=4, 20 ns clock.

1. Assert `rst_n`=0 mid-operation with `sticky`=8'hFF → all outputs 0 immediately, not waiting for a clock edge. After release, with `din`=0, outputs stay 0.
2. `mode_rise`[0]=1; `din`[0] 0→1 sampled at edge n → `level`[0]=1 and `pulse`[0]=1 at edge n+5 only, `sticky`[0]=1, `irq`=1. No other bit changes.
3. `din`[1] high for 3 cycles, then high for 4 cycles (both modes enabled):
   - 3-cycle glitch → no pulse, `level`[1] stays 0.
   - 4-cycle high → exactly one rise pulse.
4. Both modes enabled on ch2; `din`[2] high for 10 cycles then low → two single-cycle pulses 10 cycles apart. `level`[2] mirrors `din`[2] delayed by 5 cycles.
5. `clr`[0]=1 in the same cycle as a new `pulse`[0] → `sticky`[0] stays 1. `clr`[0]=1 alone → `sticky`[0]=0 at the next edge and `irq`=0 if no other flag is set.
6. `mode_fall`[3]=1, `mode_rise`[3]=0; rise then fall on ch3 while all 8 channels toggle together:
   - Ch3 rise → no pulse, but `level` updates.
   - Ch3 fall → pulse.
   - Other channels respond independently and simultaneously per their modes.

Source files
------------

// File: rtl/edge_detect_bank.sv
`default_nettype none
// ============================================================================
//  Module   : edge_detect_bank
//  Purpose  : Multi-channel edge detector. Each channel synchronises an
//             asynchronous input, debounces it and flags rising and/or
//             falling edges. Edges give one-cycle pulses and sticky flags
//             that software can clear. The flags are ORed into one interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_detect_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] mode_rise,
    input  logic [WIDTH-1:0] mode_fall,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] sticky,
    output logic             irq
);

    // The counter has to hold values 0..FILT_LEN-1. The toggle happens when
    // the next increment would reach FILT_LEN.
    localparam int                 c_cnt_w     = $clog2(FILT_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_filt_last = c_cnt_w'(FILT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_cnt_w-1:0]     r_cnt;
            logic                   r_level;
            logic                   r_pulse;
            logic                   r_sticky;
            logic                   w_s;
            logic                   w_toggle;
            logic                   w_event;

            assign w_s      = r_sync[SYNC_STAGES-1];
            // The filtered level flips on this edge. Before the flip, r_level
            // still gives the edge direction.
            assign w_toggle = (w_s != r_level) && (r_cnt == c_filt_last);
            assign w_event  = w_toggle &&
                              ((!r_level && mode_rise[i]) || (r_level && mode_fall[i]));

            // Synchroniser shift register for the raw asynchronous input.
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], din[i]};
                end
            end

            // Debounce filter. Counts cycles where the input disagrees with
            // the level, and flips the level after FILT_LEN of them in a row.
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (w_s == r_level) begin
                    r_cnt   <= '0;
                end else if (w_toggle) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt   <= r_cnt + c_cnt_one;
                end
            end

            // Pulse and sticky flag. A set in the same cycle as a clear wins
            // over the clear.
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    r_pulse  <= 1'b0;
                    r_sticky <= 1'b0;
                end else begin
                    r_pulse  <= w_event;
                    r_sticky <= (r_sticky & ~clr[i]) | w_event;
                end
            end

            assign level[i]  = r_level;
            assign pulse[i]  = r_pulse;
            assign sticky[i] = r_sticky;
        end
    endgenerate

    assign irq = |sticky;

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_detect_bank
//  Purpose  : Directed self-checking bench for edge_detect_bank, run with the
//             default parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_detect_bank;

    logic       clock;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] mode_rise;
    logic [7:0] mode_fall;
    logic [7:0] clr;
    logic [7:0] level;
    logic [7:0] pulse;
    logic [7:0] sticky;
    logic       irq;

    int checks;
    int failures;

    edge_detect_bank #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .FILT_LEN    (4)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .din       (din),
        .mode_rise (mode_rise),
        .mode_fall (mode_fall),
        .clr       (clr),
        .level     (level),
        .pulse     (pulse),
        .sticky    (sticky),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Advance one rising edge, then settle 1 ns before driving or sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (level  !== 8'h00) begin failures++; $display("FAIL reset_level actual=%h required=%h", level, 8'h00); end
        checks++; if (pulse  !== 8'h00) begin failures++; $display("FAIL reset_pulse actual=%h required=%h", pulse, 8'h00); end
        checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL reset_sticky actual=%h required=%h", sticky, 8'h00); end
        checks++; if (irq    !== 1'b0)  begin failures++; $display("FAIL reset_irq actual=%b required=%b", irq, 1'b0); end
        rst_n = 1'b1;
        // Fill every sticky flag, then pull reset in the middle of a cycle.
        din       = 8'hFF;
        mode_rise = 8'hFF;
        repeat (6) tick();
        checks++; if (sticky !== 8'hFF) begin failures++; $display("FAIL prefill_sticky actual=%h required=%h", sticky, 8'hFF); end
        checks++; if (irq    !== 1'b1)  begin failures++; $display("FAIL prefill_irq actual=%b required=%b", irq, 1'b1); end
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        checks++; if (level  !== 8'h00) begin failures++; $display("FAIL async_level actual=%h required=%h", level, 8'h00); end
        checks++; if (pulse  !== 8'h00) begin failures++; $display("FAIL async_pulse actual=%h required=%h", pulse, 8'h00); end
        checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL async_sticky actual=%h required=%h", sticky, 8'h00); end
        checks++; if (irq    !== 1'b0)  begin failures++; $display("FAIL async_irq actual=%b required=%b", irq, 1'b0); end
        din       = 8'h00;
        mode_rise = 8'h00;
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++; if ({level, pulse, sticky, irq} !== 25'd0) begin failures++; $display("FAIL post_reset_idle t=%0d actual=%h/%h/%h/%b required=0", t, level, pulse, sticky, irq); end
        end
    endtask

    task automatic test_single_rise();
        mode_rise = 8'h01;
        mode_fall = 8'h00;
        din       = 8'h01;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++; if ({level, pulse} !== 16'h0000) begin failures++; $display("FAIL rise_early t=%0d actual=%h/%h required=00/00", t, level, pulse); end
        end
        tick();
        checks++; if (level  !== 8'h01) begin failures++; $display("FAIL rise_level actual=%h required=%h", level, 8'h01); end
        checks++; if (pulse  !== 8'h01) begin failures++; $display("FAIL rise_pulse actual=%h required=%h", pulse, 8'h01); end
        checks++; if (sticky !== 8'h01) begin failures++; $display("FAIL rise_sticky actual=%h required=%h", sticky, 8'h01); end
        checks++; if (irq    !== 1'b1)  begin failures++; $display("FAIL rise_irq actual=%b required=%b", irq, 1'b1); end
        tick();
        checks++; if (pulse  !== 8'h00) begin failures++; $display("FAIL rise_pulse_width actual=%h required=%h", pulse, 8'h00); end
        checks++; if (level  !== 8'h01) begin failures++; $display("FAIL rise_level_hold actual=%h required=%h", level, 8'h01); end
    endtask

    task automatic test_glitch();
        int n_pulse;
        int n_rise;
        mode_rise = 8'h03;
        mode_fall = 8'h02;
        // A 3-cycle glitch is too short to pass the filter.
        din = 8'h03;
        repeat (3) tick();
        din = 8'h01;
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++; if (pulse[1] !== 1'b0 || level[1] !== 1'b0) begin failures++; $display("FAIL glitch_ch1 t=%0d actual=%b/%b required=0/0", t, level[1], pulse[1]); end
        end
        // A 4-cycle pulse just passes. It gives one rise, then a fall 4 cycles later.
        n_pulse = 0;
        n_rise  = 0;
        din = 8'h03;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 4) din = 8'h01;
            if (pulse[1] === 1'b1) begin
                n_pulse++;
                if (level[1] === 1'b1) n_rise++;
            end
            if (t == 6) begin
                checks++; if (pulse[1] !== 1'b1) begin failures++; $display("FAIL pass4_rise_time actual=%b required=%b", pulse[1], 1'b1); end
            end
        end
        checks++; if (n_rise  !== 1) begin failures++; $display("FAIL pass4_rise_count actual=%0d required=%0d", n_rise, 1); end
        checks++; if (n_pulse !== 2) begin failures++; $display("FAIL pass4_pulse_count actual=%0d required=%0d", n_pulse, 2); end
        checks++; if (level[1] !== 1'b0) begin failures++; $display("FAIL pass4_level_end actual=%b required=%b", level[1], 1'b0); end
    endtask

    task automatic test_rise_fall();
        logic exp_level;
        logic exp_pulse;
        mode_rise = 8'h05;
        mode_fall = 8'h06;
        din = 8'h05;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t == 10) din = 8'h01;
            exp_level = (t >= 6) && (t <= 15);
            exp_pulse = (t == 6) || (t == 16);
            checks++; if (level[2] !== exp_level) begin failures++; $display("FAIL rf_level t=%0d actual=%b required=%b", t, level[2], exp_level); end
            checks++; if (pulse[2] !== exp_pulse) begin failures++; $display("FAIL rf_pulse t=%0d actual=%b required=%b", t, pulse[2], exp_pulse); end
        end
    endtask

    task automatic test_clear();
        // Channel 0 falls. The clear is present on the same edge that sets the flag.
        mode_fall = 8'h07;
        din = 8'h00;
        repeat (5) tick();
        clr = 8'h01;
        tick();
        clr = 8'h00;
        checks++; if (pulse[0]  !== 1'b1) begin failures++; $display("FAIL clr_set_pulse actual=%b required=%b", pulse[0], 1'b1); end
        checks++; if (sticky[0] !== 1'b1) begin failures++; $display("FAIL clr_set_wins actual=%b required=%b", sticky[0], 1'b1); end
        clr = 8'hFE;
        tick();
        clr = 8'h00;
        checks++; if (sticky !== 8'h01) begin failures++; $display("FAIL clr_others actual=%h required=%h", sticky, 8'h01); end
        checks++; if (irq    !== 1'b1)  begin failures++; $display("FAIL clr_irq_held actual=%b required=%b", irq, 1'b1); end
        clr = 8'h01;
        #1;
        checks++; if (sticky[0] !== 1'b1) begin failures++; $display("FAIL clr_not_immediate actual=%b required=%b", sticky[0], 1'b1); end
        tick();
        clr = 8'h00;
        checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL clr_alone actual=%h required=%h", sticky, 8'h00); end
        checks++; if (irq    !== 1'b0)  begin failures++; $display("FAIL clr_irq_low actual=%b required=%b", irq, 1'b0); end
    endtask

    task automatic test_back_to_back();
        mode_rise = 8'hA5;
        mode_fall = 8'h5A;
        din = 8'hFF;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++; if (pulse !== 8'h00) begin failures++; $display("FAIL mix_rise_early t=%0d actual=%h required=%h", t, pulse, 8'h00); end
        end
        tick();
        checks++; if (level  !== 8'hFF) begin failures++; $display("FAIL mix_rise_level actual=%h required=%h", level, 8'hFF); end
        checks++; if (pulse  !== 8'hA5) begin failures++; $display("FAIL mix_rise_pulse actual=%h required=%h", pulse, 8'hA5); end
        checks++; if (sticky !== 8'hA5) begin failures++; $display("FAIL mix_rise_sticky actual=%h required=%h", sticky, 8'hA5); end
        // Enabling every rise mode after the toggle must not create a late pulse.
        mode_rise = 8'hFF;
        tick();
        checks++; if (pulse !== 8'h00) begin failures++; $display("FAIL mix_no_retro actual=%h required=%h", pulse, 8'h00); end
        mode_rise = 8'hA5;
        repeat (3) tick();
        din = 8'h00;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++; if (pulse !== 8'h00) begin failures++; $display("FAIL mix_fall_early t=%0d actual=%h required=%h", t, pulse, 8'h00); end
        end
        tick();
        checks++; if (level  !== 8'h00) begin failures++; $display("FAIL mix_fall_level actual=%h required=%h", level, 8'h00); end
        checks++; if (pulse  !== 8'h5A) begin failures++; $display("FAIL mix_fall_pulse actual=%h required=%h", pulse, 8'h5A); end
        checks++; if (sticky !== 8'hFF) begin failures++; $display("FAIL mix_fall_sticky actual=%h required=%h", sticky, 8'hFF); end
        tick();
        checks++; if (pulse !== 8'h00) begin failures++; $display("FAIL mix_fall_width actual=%h required=%h", pulse, 8'h00); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        din       = 8'h00;
        mode_rise = 8'h00;
        mode_fall = 8'h00;
        clr       = 8'h00;
        #1;
        test_reset();
        test_single_rise();
        test_glitch();
        test_rise_fall();
        test_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
